fifo_wptr_full_ctrl: RTL and testbench



---
 rtl/fifo_wptr_full_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_wptr_full_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-domain pointer/status controller for the dual-clock FIFO: address, Gray pointer, full, almost-full, level, overflow.
// Optional overflow event counter is built when FIFO_WPTR_OVF_CNT_EN is defined.
module fifo_wptr_full_ctrl #(
    parameter int ADDR_WIDTH    = 3,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                    Wclk,
    input  logic                    Wrst,
    input  logic                    Winc,
    input  logic [ADDR_WIDTH:0]     Wq2_rptr,
    input  logic [ADDR_WIDTH:0]     Wafull_thresh,
    input  logic                    Wovf_clr,
    output logic [ADDR_WIDTH-1:0]   Waddr,
    output logic                    Wen,
    output logic [ADDR_WIDTH:0]     Wptr,
    output logic                    Wfull,
    output logic                    Wafull,
    output logic [ADDR_WIDTH:0]     Wlevel,
`ifdef FIFO_WPTR_OVF_CNT_EN
    output logic                    Wovf,
    output logic [OVF_CNT_WIDTH-1:0] Wovf_cnt
`else
    output logic                    Wovf
`endif
);
    localparam int AW = ADDR_WIDTH;

    if (ADDR_WIDTH < 2 || OVF_CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_wptr_full_ctrl: ADDR_WIDTH must be >= 2 and OVF_CNT_WIDTH >= 1");
    end

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] wlevel_q, wlevel_d;
    logic        wfull_q, wfull_d;
    logic        wafull_q, wafull_d;
    logic        wovf_q, wovf_d;
    logic [AW:0] rbin;
    logic        accept, drop;

    assign accept = Winc & ~wfull_q;
    assign drop   = Winc &  wfull_q;

    always_comb begin
        rbin = '0;
        // Each binary bit is the XOR of all Gray bits at or above it.
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(Wq2_rptr >> i);
        end
    end

    always_comb begin
        wbin_d   = wbin_q + {{AW{1'b0}}, accept};
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wlevel_d = wbin_d - rbin;
        // Full when the next write pointer equals the read pointer with its top two Gray bits flipped.
        wfull_d  = (wptr_d == {~Wq2_rptr[AW:AW-1], Wq2_rptr[AW-2:0]});
        wafull_d = (wlevel_d >= Wafull_thresh);
        wovf_d   = drop ? 1'b1 : (Wovf_clr ? 1'b0 : wovf_q);
    end

    always_ff @(posedge Wclk) begin
        if (Wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

`ifdef FIFO_WPTR_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        // A drop in the same cycle as a clear leaves a count of one.
        if (Wovf_clr) begin
            ovf_cnt_d = drop ? OVF_CNT_WIDTH'(1) : '0;
        end else if (drop && (ovf_cnt_q != {OVF_CNT_WIDTH{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge Wclk) begin
        if (Wrst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign Wovf_cnt = ovf_cnt_q;
`endif

    assign Waddr  = wbin_q[AW-1:0];
    assign Wen    = accept;
    assign Wptr   = wptr_q;
    assign Wfull  = wfull_q;
    assign Wafull = wafull_q;
    assign Wlevel = wlevel_q;
    assign Wovf   = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Scoreboard bench for fifo_wptr_full_ctrl: a count-based occupancy model predicts every post-edge output.
module tb_fifo_wptr_full_ctrl;
    localparam int AW    = 3;
    localparam int CW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 2 * DEPTH;
    localparam int CMAX  = (1 << CW) - 1;

    logic          Wclk = 1'b0;
    logic          Wrst = 1'b1;
    logic          Winc = 1'b0;
    logic          Wovf_clr = 1'b0;
    logic [AW:0]   Wq2_rptr = '0;
    logic [AW:0]   Wafull_thresh = 4'd6;
    logic [AW-1:0] Waddr;
    logic          Wen, Wfull, Wafull, Wovf;
    logic [AW:0]   Wptr, Wlevel;
    logic [CW-1:0] Wovf_cnt;

    fifo_wptr_full_ctrl #(.ADDR_WIDTH(AW), .OVF_CNT_WIDTH(CW)) dut (
        .Wclk(Wclk), .Wrst(Wrst), .Winc(Winc), .Wq2_rptr(Wq2_rptr),
        .Wafull_thresh(Wafull_thresh), .Wovf_clr(Wovf_clr),
        .Waddr(Waddr), .Wen(Wen), .Wptr(Wptr), .Wfull(Wfull),
        .Wafull(Wafull), .Wlevel(Wlevel),
`ifdef FIFO_WPTR_OVF_CNT_EN
        .Wovf(Wovf), .Wovf_cnt(Wovf_cnt)
`else
        .Wovf(Wovf)
`endif
    );

`ifndef FIFO_WPTR_OVF_CNT_EN
    assign Wovf_cnt = '0;
`endif

    always #5 Wclk = ~Wclk;

    typedef struct {
        int addr, ptr, full, afull, level, ovf, cnt;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    // Model state: write and read counts (mod 2*DEPTH) plus flags.
    int mw = 0, mr = 0, thr = 6;
    int mfull = 0, mafull = 0, mlvl = 0, movf = 0, mcnt = 0;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & (MOD - 1);
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit inc, input bit clr, input bit rst);
        exp_t e;
        int   drop;
        @(negedge Wclk);
        Winc = inc; Wovf_clr = clr; Wrst = rst;
        Wq2_rptr = AW'(0) | (AW+1)'(gray(mr));
        Wafull_thresh = (AW+1)'(thr);
        #1;
        cmp("wen", int'(Wen), (inc && !mfull) ? 1 : 0);
        if (rst) begin
            mw = 0; mlvl = 0; mfull = 0; mafull = 0; movf = 0; mcnt = 0;
        end else begin
            drop = (inc && mfull) ? 1 : 0;
            if (inc && !mfull) mw = (mw + 1) % MOD;
            mlvl   = (mw - mr + MOD) % MOD;
            mfull  = (mlvl == DEPTH) ? 1 : 0;
            mafull = (mlvl >= thr) ? 1 : 0;
            if (drop) movf = 1;
            else if (clr) movf = 0;
            if (clr) mcnt = drop;
            else if (drop && mcnt < CMAX) mcnt++;
        end
        e.addr = mw % DEPTH; e.ptr = gray(mw); e.full = mfull; e.afull = mafull;
        e.level = mlvl; e.ovf = movf; e.cnt = mcnt;
        sbq.push_back(e);
    endtask

    task automatic settle();
        @(posedge Wclk);
        #2;
    endtask

    always @(posedge Wclk) begin : monitor
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            cmp("waddr",  int'(Waddr),  e.addr);
            cmp("wptr",   int'(Wptr),   e.ptr);
            cmp("wfull",  int'(Wfull),  e.full);
            cmp("wafull", int'(Wafull), e.afull);
            cmp("wlevel", int'(Wlevel), e.level);
            cmp("wovf",   int'(Wovf),   e.ovf);
`ifdef FIFO_WPTR_OVF_CNT_EN
            cmp("wovf_cnt", int'(Wovf_cnt), e.cnt);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1, p2;
        // 1: reset and fill
        thr = 6; mr = 0;
        step(0, 0, 1); step(0, 0, 1);
        repeat (DEPTH) step(1, 0, 0);
        settle();
        cmp("fill_full", int'(Wfull), 1);
        cmp("fill_level", int'(Wlevel), 8);
        cmp("fill_ptr", int'(Wptr), 4'b1100);
        // 2: overflow, clear, clear with drop
        repeat (3) step(1, 0, 0);
        settle();
        cmp("ovf_set", int'(Wovf), 1);
        cmp("ovf_ptr_held", int'(Wptr), 4'b1100);
`ifdef FIFO_WPTR_OVF_CNT_EN
        cmp("ovf_cnt3", int'(Wovf_cnt), 3);
`endif
        step(0, 1, 0);
        step(1, 1, 0);
        settle();
        cmp("ovf_clr_vs_set", int'(Wovf), 1);
`ifdef FIFO_WPTR_OVF_CNT_EN
        cmp("ovf_cnt_clr_drop", int'(Wovf_cnt), 1);
`endif
        // 3: one read releases full
        mr = 1;
        step(0, 0, 0);
        settle();
        cmp("release_full", int'(Wfull), 0);
        cmp("release_level", int'(Wlevel), 7);
        step(1, 0, 0);
        settle();
        cmp("refill_full", int'(Wfull), 1);
        cmp("refill_ptr", int'(Wptr), 4'b1101);
        // counter saturation
        repeat (CMAX + 4) step(1, 0, 0);
        // 4: wrap-around with read pointer lagging two cycles
        mr = 0;
        step(0, 1, 1);
        p1 = 0; p2 = 0;
        for (int i = 0; i < 40; i++) begin
            mr = p2;
            step(1, 0, 0);
            p2 = p1; p1 = mw;
            settle();
            total++;
            if (Wlevel > 2 || Wfull) begin
                bad++;
                $display("FAIL wrap_level: level %0d full %0d exceeds bound", Wlevel, Wfull);
            end
        end
        // 5: reset mid-stream
        mr = 0;
        step(0, 0, 1);
        repeat (5) step(1, 0, 0);
        step(1, 0, 1);
        settle();
        cmp("rst_level", int'(Wlevel), 0);
        cmp("rst_ptr", int'(Wptr), 0);
        step(1, 0, 0);
        settle();
        cmp("resume_addr", int'(Waddr), 1);
        // 6: threshold boundaries
        thr = 0;
        step(0, 0, 1);
        step(0, 0, 0);
        settle();
        cmp("thr0_afull", int'(Wafull), 1);
        thr = 9;
        step(0, 0, 1);
        repeat (DEPTH + 1) step(1, 0, 0);
        settle();
        cmp("thr9_full", int'(Wfull), 1);
        cmp("thr9_afull", int'(Wafull), 0);
        // random traffic
        thr = 5;
        for (int i = 0; i < 400; i++) begin
            bit rst;
            if (i % 80 == 0) thr = int'($urandom_range(0, 9));
            rst = ($urandom_range(0, 99) == 0);
            if (rst) mr = 0;
            else if (((mw - mr + MOD) % MOD) > 0 && $urandom_range(0, 9) < 4) mr = (mr + 1) % MOD;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, rst);
        end
        repeat (2) @(posedge Wclk);
        #3;
        cmp("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
